// File: rtl/s1494_gen_pkg.sv
// rtl/s1494_gen_pkg.sv - shared types and default parameters for the s1494_gen controller
package s1494_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ch_state_t;

    localparam int DEF_NCH   = 4;
    localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/s1494_gen_ch.sv
// rtl/s1494_gen_ch.sv - one channel FSM with its beat counter
import s1494_gen_pkg::*;

module s1494_gen_ch #(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CK,
    input  logic             CLR,
    input  logic             req,
    input  logic [CNT_W-1:0] len,
    input  logic             dec,
    output ch_state_t        state,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = len;
                state_d = (len == '0) ? DONE : RUN;
            end
            RUN: begin
                // dec only arrives while this channel owns the accepted beat, so cnt_q >= 1 here
                if (dec) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (CLR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;
    assign cnt   = cnt_q;
    assign done  = (state_q == DONE);

endmodule

// File: rtl/s1494_gen_ctrl.sv
// rtl/s1494_gen_ctrl.sv - NCH channel FSMs sharing a round-robin arbitrated beat port; S1494_GEN_ERR_EN enables sticky err
import s1494_gen_pkg::*;

module s1494_gen_ctrl #(
    parameter int NCH   = DEF_NCH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int CH_W  = $clog2(NCH)
) (
    input  logic                 CK,
    input  logic                 CLR,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*CNT_W-1:0] len,
    input  logic                 hold,
    output logic                 out_valid,
    output logic [CH_W-1:0]      out_ch,
    output logic [CNT_W-1:0]     out_cnt,
    input  logic                 out_ready,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done,
    output logic [NCH-1:0]       err
);

    ch_state_t        st    [NCH];
    logic [CNT_W-1:0] cnt_a [NCH];
    logic [NCH-1:0]   run;
    logic [NCH-1:0]   dec;

    logic             out_valid_q, out_valid_d;
    logic [CH_W-1:0]  out_ch_q, out_ch_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;

    logic             accept;
    logic             found;
    logic [CH_W-1:0]  pick;
    logic [CH_W-1:0]  cand;

    assign accept = out_valid_q && out_ready;
    assign dec    = accept ? (NCH'(1) << out_ch_q) : '0;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        s1494_gen_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .CK    (CK),
            .CLR   (CLR),
            .req   (req[k]),
            .len   (len[k*CNT_W +: CNT_W]),
            .dec   (dec[k]),
            .state (st[k]),
            .cnt   (cnt_a[k]),
            .done  (done[k])
        );
        assign run[k]  = (st[k] == RUN);
        assign busy[k] = (st[k] != IDLE);
    end

    // First RUN channel at or after ptr, wrapping modulo NCH
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = CH_W'((int'(ptr_q) + i) % NCH);
            if (!found && run[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // An acceptance needs out_valid high, so issuing only from out_valid low yields one bubble per beat
    always_comb begin
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_cnt_d   = out_cnt_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b0;
            ptr_d       = (out_ch_q == CH_W'(NCH - 1)) ? '0 : out_ch_q + CH_W'(1);
        end else if (!out_valid_q && !hold && found) begin
            out_valid_d = 1'b1;
            out_ch_d    = pick;
            out_cnt_d   = cnt_a[pick];
        end
    end

    always_ff @(posedge CK) begin
        if (CLR) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_cnt_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_cnt_q   <= out_cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_cnt   = out_cnt_q;

`ifdef S1494_GEN_ERR_EN
    logic [NCH-1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        for (int k = 0; k < NCH; k++) begin
            if (req[k] && st[k] != IDLE) begin
                err_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (CLR) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = '0;
`endif

endmodule

// File: tb/tb_s1494_gen_ctrl.sv
// tb/tb_s1494_gen_ctrl.sv - directed self-checking bench for s1494_gen_ctrl
module tb_s1494_gen_ctrl;

    logic        CK = 1'b0;
    logic        CLR;
    logic [3:0]  req;
    logic [15:0] len;
    logic        hold;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [3:0]  out_cnt;
    logic        out_ready;
    logic [3:0]  busy;
    logic [3:0]  done;
    logic [3:0]  err;

    int tests = 0;
    int fails = 0;

`ifdef S1494_GEN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    s1494_gen_ctrl #(.NCH(4), .CNT_W(4)) dut (
        .CK        (CK),
        .CLR       (CLR),
        .req       (req),
        .len       (len),
        .hold      (hold),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_cnt   (out_cnt),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 CK = ~CK;

    task automatic step;
        @(posedge CK);
        #1;
    endtask

    task automatic do_clr;
        CLR = 1'b1; req = '0; len = '0; hold = 1'b0; out_ready = 1'b0;
        step;
        CLR = 1'b0;
    endtask

    task automatic test_reset;
        CLR = 1'b1; req = 4'hF; len = 16'hFFFF; hold = 1'b0; out_ready = 1'b1;
        step;
        step;
        tests++;
        if ({out_valid, out_ch, out_cnt, busy, done, err} !== 15'd0) begin
            fails++;
            $display("FAIL reset: got v=%0b ch=%0d cnt=%0d busy=%b done=%b err=%b, need all 0",
                     out_valid, out_ch, out_cnt, busy, done, err);
        end
        CLR = 1'b0; req = '0; len = '0; out_ready = 1'b0;
    endtask

    task automatic test_single;
        bit ev[9] = '{0, 0, 1, 0, 1, 0, 1, 0, 0};
        int ec[9] = '{0, 0, 3, 0, 2, 0, 1, 0, 0};
        bit ed[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        bit eb[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        do_clr;
        req = 4'b0010; len = 16'h0030; out_ready = 1'b1;
        for (int e = 0; e < 9; e++) begin
            step;
            req = '0;
            tests++;
            if (out_valid !== ev[e] || done[1] !== ed[e] || busy[1] !== eb[e] ||
                (ev[e] && (out_ch !== 2'd1 || out_cnt !== 4'(ec[e])))) begin
                fails++;
                $display("FAIL single e%0d: got v=%0b ch=%0d cnt=%0d done1=%0b busy1=%0b, need v=%0b ch=1 cnt=%0d done1=%0b busy1=%0b",
                         e, out_valid, out_ch, out_cnt, done[1], busy[1], ev[e], ec[e], ed[e], eb[e]);
            end
        end
    endtask

    task automatic test_zero_len;
        bit ed[4] = '{0, 1, 0, 0};
        bit eb[4] = '{1, 1, 0, 0};
        do_clr;
        req = 4'b0100; len = 16'h0000; out_ready = 1'b1;
        for (int e = 0; e < 4; e++) begin
            step;
            req = '0;
            tests++;
            if (out_valid !== 1'b0 || done !== {1'b0, ed[e], 2'b00} || busy[2] !== eb[e]) begin
                fails++;
                $display("FAIL zero_len e%0d: got v=%0b done=%b busy2=%0b, need v=0 done2=%0b busy2=%0b",
                         e, out_valid, done, busy[2], ed[e], eb[e]);
            end
        end
    endtask

    task automatic test_round_robin;
        int exp_ch[4]  = '{0, 3, 0, 3};
        int exp_cnt[4] = '{2, 2, 1, 1};
        int n = 0;
        do_clr;
        req = 4'b1001; len = 16'h2002; out_ready = 1'b1;
        step;
        req = '0;
        for (int c = 0; c < 20; c++) begin
            step;
            if (out_valid && n < 4) begin
                tests++;
                if (out_ch !== 2'(exp_ch[n]) || out_cnt !== 4'(exp_cnt[n])) begin
                    fails++;
                    $display("FAIL rr beat%0d: got ch=%0d cnt=%0d, need ch=%0d cnt=%0d",
                             n, out_ch, out_cnt, exp_ch[n], exp_cnt[n]);
                end
                n++;
            end
        end
        tests++;
        if (n !== 4 || busy !== 4'b0000) begin
            fails++;
            $display("FAIL rr count: got %0d beats busy=%b, need 4 beats busy=0000", n, busy);
        end
    endtask

    task automatic test_backpressure;
        do_clr;
        req = 4'b0010; len = 16'h0020; out_ready = 1'b0;
        step;
        req = '0;
        step;
        step;
        for (int i = 0; i < 5; i++) begin
            hold = (i >= 2);
            step;
            tests++;
            if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_cnt !== 4'd2) begin
                fails++;
                $display("FAIL bp stall%0d: got v=%0b ch=%0d cnt=%0d, need v=1 ch=1 cnt=2",
                         i, out_valid, out_ch, out_cnt);
            end
        end
        hold = 1'b0; out_ready = 1'b1;
        step;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp bubble: got v=%0b, need 0", out_valid);
        end
        step;
        tests++;
        if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_cnt !== 4'd1) begin
            fails++;
            $display("FAIL bp second: got v=%0b ch=%0d cnt=%0d, need v=1 ch=1 cnt=1",
                     out_valid, out_ch, out_cnt);
        end
        step;
        tests++;
        if (out_valid !== 1'b0 || done !== 4'b0010) begin
            fails++;
            $display("FAIL bp done: got v=%0b done=%b, need v=0 done=0010", out_valid, done);
        end
    endtask

    task automatic test_hold;
        do_clr;
        hold = 1'b1; req = 4'b0001; len = 16'h0001; out_ready = 1'b1;
        step;
        req = '0;
        for (int i = 0; i < 6; i++) begin
            step;
            tests++;
            if (out_valid !== 1'b0 || busy[0] !== 1'b1) begin
                fails++;
                $display("FAIL hold cyc%0d: got v=%0b busy0=%0b, need v=0 busy0=1", i, out_valid, busy[0]);
            end
        end
        hold = 1'b0;
        step;
        tests++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_cnt !== 4'd1) begin
            fails++;
            $display("FAIL hold release: got v=%0b ch=%0d cnt=%0d, need v=1 ch=0 cnt=1",
                     out_valid, out_ch, out_cnt);
        end
        step;
        tests++;
        if (out_valid !== 1'b0 || done !== 4'b0001) begin
            fails++;
            $display("FAIL hold done: got v=%0b done=%b, need v=0 done=0001", out_valid, done);
        end
    endtask

    task automatic test_reset_midbeat;
        do_clr;
        req = 4'b0100; len = 16'h0300; out_ready = 1'b0;
        step;
        req = '0;
        step;
        step;
        tests++;
        if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_cnt !== 4'd3) begin
            fails++;
            $display("FAIL midbeat pre: got v=%0b ch=%0d cnt=%0d, need v=1 ch=2 cnt=3",
                     out_valid, out_ch, out_cnt);
        end
        CLR = 1'b1; out_ready = 1'b1;
        step;
        CLR = 1'b0;
        tests++;
        if ({out_valid, out_ch, out_cnt, busy, done, err} !== 15'd0) begin
            fails++;
            $display("FAIL midbeat clr: got v=%0b ch=%0d cnt=%0d busy=%b done=%b err=%b, need all 0",
                     out_valid, out_ch, out_cnt, busy, done, err);
        end
        for (int i = 0; i < 3; i++) begin
            step;
            tests++;
            if (out_valid !== 1'b0 || busy !== 4'b0000 || done !== 4'b0000) begin
                fails++;
                $display("FAIL midbeat after%0d: got v=%0b busy=%b done=%b, need 0", i, out_valid, busy, done);
            end
        end
    endtask

    task automatic test_err;
        do_clr;
        req = 4'b0001; len = 16'h0003; out_ready = 1'b0;
        step;
        req = '0;
        step;
        step;
        req = 4'b0001; len = 16'h0009;
        step;
        req = '0;
        tests++;
        if (err !== {3'b000, ERR_EN} || out_valid !== 1'b1 || out_cnt !== 4'd3) begin
            fails++;
            $display("FAIL err set: got err=%b v=%0b cnt=%0d, need err0=%0b v=1 cnt=3",
                     err, out_valid, out_cnt, ERR_EN);
        end
        out_ready = 1'b1;
        step;
        step;
        tests++;
        if (err !== {3'b000, ERR_EN} || out_valid !== 1'b1 || out_ch !== 2'd0 || out_cnt !== 4'd2) begin
            fails++;
            $display("FAIL err sticky: got err=%b v=%0b ch=%0d cnt=%0d, need err0=%0b v=1 ch=0 cnt=2",
                     err, out_valid, out_ch, out_cnt, ERR_EN);
        end
        do_clr;
        tests++;
        if (err !== 4'b0000) begin
            fails++;
            $display("FAIL err clear: got err=%b, need 0000", err);
        end
    endtask

    initial begin
        CLR = 1'b1; req = '0; len = '0; hold = 1'b0; out_ready = 1'b0;
        test_reset;
        test_single;
        test_zero_len;
        test_round_robin;
        test_backpressure;
        test_hold;
        test_reset_midbeat;
        test_err;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
